// File: rtl/norm_pipe.sv
// -----------------------------------------------------------------------------
// norm_pipe : L1-normalisation stage for the SFP output path.
//
// An accumulate (acc) cycle sums |lane| over the COL signed lanes of sfp_in and
// pushes that row sum into a DEPTH-entry FIFO. A divide (div) cycle pops the
// oldest sum and divides every lane of the current sfp_in by it. The quotient
// is truncated toward zero and saturated to the lane range. The dividend is
// lane <<< FRAC, so FRAC sets the number of fraction bits in the result.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   acc        in   push |row sum| of sfp_in this cycle
//   div        in   pop FIFO head and divide sfp_in by it this cycle
//   sfp_in     in   COL*BW_PSUM signed lanes, lane i at [BW_PSUM*i +: BW_PSUM]
//   sfp_out    out  registered quotients, same packing as sfp_in
//   out_valid  out  sfp_out was updated by the previous cycle's accepted pop
//   fifo_full  out  count == DEPTH
//   fifo_empty out  count == 0
//   count      out  number of queued sums
//   err        out  sticky {div_by_zero, underflow, overflow}
// -----------------------------------------------------------------------------
module norm_pipe #(
  parameter int COL     = 8,
  parameter int BW_PSUM = 16,
  parameter int SUM_BW  = 20,
  parameter int DEPTH   = 16,
  parameter int FRAC    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc,
  input  logic                     div,
  input  logic [COL*BW_PSUM-1:0]   sfp_in,
  output logic [COL*BW_PSUM-1:0]   sfp_out,
  output logic                     out_valid,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [2:0]               err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = BW_PSUM + FRAC;
  localparam int VW = SUM_BW + 1;
  // One spare bit above the wider operand keeps the shifted dividend and the
  // zero-extended divisor both representable as positive/negative signed values.
  localparam int QW = ((DW > VW) ? DW : VW) + 1;

  localparam logic signed [QW-1:0] SAT_MAX = {{(QW-BW_PSUM+1){1'b0}}, {(BW_PSUM-1){1'b1}}};
  localparam logic signed [QW-1:0] SAT_MIN = {{(QW-BW_PSUM+1){1'b1}}, {(BW_PSUM-1){1'b0}}};

  // FIFO storage and control state
  logic [SUM_BW-1:0]       mem_r [DEPTH];
  logic [AW-1:0]           wr_ptr_r;
  logic [AW-1:0]           rd_ptr_r;
  logic [CW-1:0]           count_r;
  logic [2:0]              err_r;
  logic [COL*BW_PSUM-1:0]  sfp_out_r;
  logic                    out_valid_r;

  // Combinational datapath signals
  logic                    full_s;
  logic                    empty_s;
  logic                    pop_ok_s;
  logic                    push_ok_s;
  logic [SUM_BW-1:0]       row_sum_s;
  logic [SUM_BW-1:0]       head_s;
  logic                    head_zero_s;
  logic [COL*BW_PSUM-1:0]  quot_s;

  assign full_s      = (count_r == CW'(DEPTH));
  assign empty_s     = (count_r == {CW{1'b0}});
  assign head_s      = mem_r[rd_ptr_r];
  assign head_zero_s = (head_s == {SUM_BW{1'b0}});

  // An empty FIFO rejects the pop even when a push arrives in the same cycle.
  assign pop_ok_s  = div & ~empty_s;
  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign push_ok_s = acc & (~full_s | pop_ok_s);

  // Row sum of lane magnitudes; abs is one bit wider so the most negative lane
  // maps to +2^(BW_PSUM-1) without wrapping.
  always_comb begin
    logic signed [BW_PSUM-1:0] lane_v;
    logic [BW_PSUM:0]          ext_v;
    logic [BW_PSUM:0]          abs_v;
    row_sum_s = {SUM_BW{1'b0}};
    for (int i = 0; i < COL; i++) begin
      lane_v = sfp_in[BW_PSUM*i +: BW_PSUM];
      ext_v  = {lane_v[BW_PSUM-1], lane_v};
      if (lane_v[BW_PSUM-1]) begin
        abs_v = ~ext_v + {{BW_PSUM{1'b0}}, 1'b1};
      end else begin
        abs_v = ext_v;
      end
      row_sum_s = row_sum_s + {{(SUM_BW-BW_PSUM-1){1'b0}}, abs_v};
    end
  end

  // Per-lane signed divide by the FIFO head, truncating toward zero, then
  // saturating to the lane range. A zero divisor yields zero lanes.
  always_comb begin
    logic signed [QW-1:0] dvd_v;
    logic signed [QW-1:0] dvs_v;
    logic signed [QW-1:0] q_v;
    logic [BW_PSUM-1:0]   lane_v;
    quot_s = {(COL*BW_PSUM){1'b0}};
    dvs_v  = {{(QW-SUM_BW){1'b0}}, head_s};
    for (int i = 0; i < COL; i++) begin
      lane_v = sfp_in[BW_PSUM*i +: BW_PSUM];
      dvd_v  = {{(QW-BW_PSUM){lane_v[BW_PSUM-1]}}, lane_v};
      dvd_v  = dvd_v <<< FRAC;
      if (head_zero_s) begin
        q_v = {QW{1'b0}};
      end else begin
        q_v = dvd_v / dvs_v;
      end
      if (q_v > SAT_MAX) begin
        quot_s[BW_PSUM*i +: BW_PSUM] = SAT_MAX[BW_PSUM-1:0];
      end else if (q_v < SAT_MIN) begin
        quot_s[BW_PSUM*i +: BW_PSUM] = SAT_MIN[BW_PSUM-1:0];
      end else begin
        quot_s[BW_PSUM*i +: BW_PSUM] = q_v[BW_PSUM-1:0];
      end
    end
  end

  // FIFO storage write; contents are not reset and are meaningless until written.
  always_ff @(posedge clk) begin
    if (reset && push_ok_s) begin
      mem_r[wr_ptr_r] <= row_sum_s;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered quotient output; holds its value when no pop is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sfp_out_r   <= {(COL*BW_PSUM){1'b0}};
      out_valid_r <= 1'b0;
    end else if (pop_ok_s) begin
      sfp_out_r   <= quot_s;
      out_valid_r <= 1'b1;
    end else begin
      sfp_out_r   <= sfp_out_r;
      out_valid_r <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_r <= 3'b000;
    end else begin
      err_r <= err_r | {pop_ok_s & head_zero_s, div & ~pop_ok_s, acc & ~push_ok_s};
    end
  end

  assign sfp_out    = sfp_out_r;
  assign out_valid  = out_valid_r;
  assign fifo_full  = full_s;
  assign fifo_empty = empty_s;
  assign count      = count_r;
  assign err        = err_r;

endmodule

// File: tb/tb_norm_pipe.sv
// -----------------------------------------------------------------------------
// tb_norm_pipe : directed self-checking bench for norm_pipe.
// Two instances share stimulus: u0 with FRAC=0 and u8 with FRAC=8. Expected
// values are hand-computed constants derived from the L1-normalisation rules.
// -----------------------------------------------------------------------------
module tb_norm_pipe;

  logic         clk;
  logic         reset;
  logic         acc;
  logic         div;
  logic [127:0] sfp_in;

  logic [127:0] o0_out, o8_out;
  logic         o0_vld, o8_vld;
  logic         o0_full, o8_full;
  logic         o0_empty, o8_empty;
  logic [4:0]   o0_cnt, o8_cnt;
  logic [2:0]   o0_err, o8_err;

  int n_checks;
  int n_fail;

  norm_pipe #(.COL(8), .BW_PSUM(16), .SUM_BW(20), .DEPTH(16), .FRAC(0)) u0 (
    .clk(clk), .reset(reset), .acc(acc), .div(div), .sfp_in(sfp_in),
    .sfp_out(o0_out), .out_valid(o0_vld), .fifo_full(o0_full),
    .fifo_empty(o0_empty), .count(o0_cnt), .err(o0_err)
  );

  norm_pipe #(.COL(8), .BW_PSUM(16), .SUM_BW(20), .DEPTH(16), .FRAC(8)) u8 (
    .clk(clk), .reset(reset), .acc(acc), .div(div), .sfp_in(sfp_in),
    .sfp_out(o8_out), .out_valid(o8_vld), .fifo_full(o8_full),
    .fifo_empty(o8_empty), .count(o8_cnt), .err(o8_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [15:0] v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  // Drive one cycle of stimulus; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic a, input logic d, input logic [127:0] row);
    acc = a;
    div = d;
    sfp_in = row;
    @(posedge clk);
    #1;
    acc = 1'b0;
    div = 1'b0;
    sfp_in = 128'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    acc      = 1'b0;
    div      = 1'b0;
    sfp_in   = 128'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_count", o0_cnt, 128'd0);
    chk("rst_empty", o0_empty, 128'd1);
    chk("rst_full", o0_full, 128'd0);
    chk("rst_err", o0_err, 128'd0);
    chk("rst_vld", o0_vld, 128'd0);
    chk("rst_out8", o8_out, 128'd0);
    reset = 1'b1;

    // FRAC=8: lanes 4, sum 32 -> 1024/32 = 32
    cyc(1'b1, 1'b0, rep(16'd4));
    chk("push_count", o0_cnt, 128'd1);
    chk("push_empty", o0_empty, 128'd0);
    cyc(1'b0, 1'b1, rep(16'd4));
    chk("div32_vld", o8_vld, 128'd1);
    chk("div32_out", o8_out, rep(16'd32));
    cyc(1'b0, 1'b0, rep(16'd9));
    chk("idle_vld", o8_vld, 128'd0);
    chk("idle_hold", o8_out, rep(16'd32));
    // lanes -8 over sum 32 -> -2048/32 = -64
    cyc(1'b1, 1'b0, rep(16'd4));
    cyc(1'b0, 1'b1, rep(16'hFFF8));
    chk("div_neg64", o8_out, rep(16'hFFC0));

    // FRAC=0: lane0 = -32768, sum 32768 with no abs wrap -> -1
    cyc(1'b1, 1'b0, {112'd0, 16'h8000});
    cyc(1'b0, 1'b1, {112'd0, 16'h8000});
    chk("abs_nowrap", o0_out, {112'd0, 16'hFFFF});

    // FRAC=8: sum 1, lanes +/-1000 saturate
    cyc(1'b1, 1'b0, {112'd0, 16'd1});
    cyc(1'b0, 1'b1, {96'd0, 16'hFC18, 16'd1000});
    chk("saturate", o8_out, {96'd0, 16'h8000, 16'h7FFF});
    chk("no_err_yet", o0_err, 128'd0);
    chk("drained", o0_cnt, 128'd0);

    // FIFO full, overflow, and push+pop across the pointer wrap (FRAC=0)
    for (int k = 1; k <= 16; k++) cyc(1'b1, 1'b0, {112'd0, 16'(10 * k)});
    chk("full_flag", o0_full, 128'd1);
    chk("full_count", o0_cnt, 128'd16);
    cyc(1'b1, 1'b0, {112'd0, 16'd5});
    chk("ovf_err", o0_err, 128'd1);
    chk("ovf_count", o0_cnt, 128'd16);
    cyc(1'b1, 1'b1, {112'd0, 16'd1000});
    chk("pushpop_q", o0_out, {112'd0, 16'd100});
    chk("pushpop_cnt", o0_cnt, 128'd16);
    for (int k = 2; k <= 16; k++) begin
      cyc(1'b0, 1'b1, {112'd0, 16'd1000});
      chk($sformatf("order_%0d", k), o0_out, {112'd0, 16'(1000 / (10 * k))});
    end
    cyc(1'b0, 1'b1, {112'd0, 16'd1000});
    chk("wrap_entry", o0_out, {112'd0, 16'd1});
    chk("wrap_empty", o0_empty, 128'd1);

    // Underflow, then divide by zero
    do_reset();
    chk("rst2_err", o0_err, 128'd0);
    cyc(1'b0, 1'b1, rep(16'd4));
    chk("udf_err", o0_err, 128'd2);
    chk("udf_vld", o0_vld, 128'd0);
    cyc(1'b1, 1'b0, 128'd0);
    cyc(1'b0, 1'b1, rep(16'd7));
    chk("dz_out", o0_out, 128'd0);
    chk("dz_vld", o0_vld, 128'd1);
    chk("dz_err", o0_err, 128'd6);

    // Mid-stream reset discards queue, output and errors
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, rep(16'd1));
    cyc(1'b0, 1'b1, rep(16'd16));
    chk("pre_rst_out", o0_out, rep(16'd2));
    chk("pre_rst_cnt", o0_cnt, 128'd4);
    do_reset();
    chk("mid_rst_cnt", o0_cnt, 128'd0);
    chk("mid_rst_empty", o0_empty, 128'd1);
    chk("mid_rst_out", o0_out, 128'd0);
    chk("mid_rst_err", o0_err, 128'd0);
    cyc(1'b0, 1'b1, rep(16'd16));
    chk("post_rst_udf", o0_err, 128'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
